// File: rtl/ctrl_pkg.sv
// Shared encodings for the multicycle controller: opcodes, functs, state
// codes, ALU operations and the datapath mux select codes.
package ctrl_pkg;

  // Instruction opcodes (IR[31:26])
  localparam logic [5:0] OP_R    = 6'h00;
  localparam logic [5:0] OP_J    = 6'h02;
  localparam logic [5:0] OP_JAL  = 6'h03;
  localparam logic [5:0] OP_BEQ  = 6'h04;
  localparam logic [5:0] OP_ADDI = 6'h08;
  localparam logic [5:0] OP_LUI  = 6'h0f;
  localparam logic [5:0] OP_LW   = 6'h23;
  localparam logic [5:0] OP_SW   = 6'h2b;

  // R-type function codes (IR[5:0])
  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_SLT = 6'h2a;

  // Controller states; the code is also exported on state_dbg
  typedef enum logic [4:0] {
    S_FETCH    = 5'd0,
    S_DECODE   = 5'd1,
    S_EXEC_R   = 5'd2,
    S_WB_R     = 5'd3,
    S_EXEC_I   = 5'd4,
    S_WB_I     = 5'd5,
    S_MEM_ADDR = 5'd6,
    S_MEM_RD   = 5'd7,
    S_WB_LW    = 5'd8,
    S_MEM_WR   = 5'd9,
    S_BRANCH   = 5'd10,
    S_JUMP     = 5'd11,
    S_JAL      = 5'd12,
    S_LUI      = 5'd13,
    S_EXC      = 5'd14
  } state_e;

  // ALU operation codes
  localparam logic [2:0] ALU_ADD = 3'd0;
  localparam logic [2:0] ALU_SUB = 3'd1;
  localparam logic [2:0] ALU_AND = 3'd2;
  localparam logic [2:0] ALU_OR  = 3'd3;
  localparam logic [2:0] ALU_SLT = 3'd4;

  // Register-file write data select
  localparam logic [2:0] M2R_ALUOUT = 3'd0;
  localparam logic [2:0] M2R_MDR    = 3'd1;
  localparam logic [2:0] M2R_PC     = 3'd2;
  localparam logic [2:0] M2R_LUI    = 3'd3;
  localparam logic [2:0] M2R_SLT    = 3'd4;

  // PC next-value select
  localparam logic [1:0] PCS_ALU    = 2'd0;
  localparam logic [1:0] PCS_ALUOUT = 2'd1;
  localparam logic [1:0] PCS_JUMP   = 2'd2;
  localparam logic [1:0] PCS_EXC    = 2'd3;

  // ALU B operand select
  localparam logic [1:0] SRCB_B      = 2'd0;
  localparam logic [1:0] SRCB_FOUR   = 2'd1;
  localparam logic [1:0] SRCB_IMM    = 2'd2;
  localparam logic [1:0] SRCB_IMM_SH = 2'd3;

  // Register-file destination select
  localparam logic [1:0] RD_RT = 2'd0;
  localparam logic [1:0] RD_RD = 2'd1;
  localparam logic [1:0] RD_RA = 2'd2;

  // True for the R-type functs the controller implements
  function automatic logic funct_legal(input logic [5:0] funct);
    return (funct == FN_ADD) || (funct == FN_SUB) || (funct == FN_AND) ||
           (funct == FN_OR)  || (funct == FN_SLT);
  endfunction

  // ALU operation an R-type funct asks for
  function automatic logic [2:0] alu_op_for_funct(input logic [5:0] funct);
    case (funct)
      FN_SUB:  return ALU_SUB;
      FN_AND:  return ALU_AND;
      FN_OR:   return ALU_OR;
      FN_SLT:  return ALU_SLT;
      default: return ALU_ADD;
    endcase
  endfunction

endpackage

// File: rtl/ctrl_wait_counter.sv
// Saturating wait-state counter used to stretch memory accesses.
// done is high once the count has reached MEM_WAIT.
module ctrl_wait_counter #(
  parameter int unsigned MEM_WAIT = 1
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clear,
  input  logic enable,
  output logic done
);

  localparam int CW = $clog2(MEM_WAIT + 2);

  logic [CW-1:0] count_q;
  logic [CW-1:0] count_d;

  // Next count: clear wins, otherwise count up and hold at MEM_WAIT
  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (enable && (count_q != CW'(MEM_WAIT))) begin
      count_d = count_q + CW'(1);
    end
  end

  // Count register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign done = (count_q == CW'(MEM_WAIT));

endmodule

// File: rtl/multicycle_ctrl.sv
// Moore control FSM for the multicycle datapath. Outputs decode the
// registered state (plus stable IR fields), so they change only after
// the clock edge that moves the state.
module multicycle_ctrl
  import ctrl_pkg::*;
#(
  parameter int unsigned MEM_WAIT = 1
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       zero,
  input  logic       overflow,
  output logic       pc_write,
  output logic       pc_write_cond,
  output logic       i_or_d,
  output logic       mem_rd,
  output logic       mem_wr,
  output logic       ir_write,
  output logic [1:0] reg_dst,
  output logic [2:0] mem_to_reg,
  output logic       reg_write,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [2:0] alu_op,
  output logic [1:0] pc_source,
  output logic       epc_write,
  output logic [4:0] state_dbg
);

  state_e state_q;
  state_e state_d;
  logic   wait_done;
  logic   wait_en;

  // The branch decision is made in the datapath by gating pc_write_cond
  // with zero, so the controller only passes it through here.
  logic unused_zero;
  assign unused_zero = zero;

  ctrl_wait_counter #(
    .MEM_WAIT (MEM_WAIT)
  ) u_wait (
    .clk     (clk),
    .reset_n (reset_n),
    .clear   (state_d != state_q),
    .enable  (wait_en),
    .done    (wait_done)
  );

  // Next-state selection and per-state control outputs
  always_comb begin
    state_d       = state_q;
    wait_en       = 1'b0;
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    i_or_d        = 1'b0;
    mem_rd        = 1'b0;
    mem_wr        = 1'b0;
    ir_write      = 1'b0;
    reg_dst       = RD_RT;
    mem_to_reg    = M2R_ALUOUT;
    reg_write     = 1'b0;
    alu_src_a     = 1'b0;
    alu_src_b     = SRCB_B;
    alu_op        = ALU_ADD;
    pc_source     = PCS_ALU;
    epc_write     = 1'b0;
    case (state_q)
      S_FETCH: begin
        mem_rd    = 1'b1;
        alu_src_b = SRCB_FOUR;
        wait_en   = 1'b1;
        if (wait_done) begin
          ir_write = 1'b1;
          pc_write = 1'b1;
          state_d  = S_DECODE;
        end
      end
      S_DECODE: begin
        alu_src_b = SRCB_IMM_SH;
        case (opcode)
          OP_R:            state_d = funct_legal(funct) ? S_EXEC_R : S_EXC;
          OP_ADDI:         state_d = S_EXEC_I;
          OP_LW, OP_SW:    state_d = S_MEM_ADDR;
          OP_BEQ:          state_d = S_BRANCH;
          OP_J:            state_d = S_JUMP;
          OP_JAL:          state_d = S_JAL;
          OP_LUI:          state_d = S_LUI;
          default:         state_d = S_EXC;
        endcase
      end
      S_EXEC_R: begin
        alu_src_a = 1'b1;
        alu_op    = alu_op_for_funct(funct);
        if (((funct == FN_ADD) || (funct == FN_SUB)) && overflow) begin
          state_d = S_EXC;
        end else begin
          state_d = S_WB_R;
        end
      end
      S_WB_R: begin
        reg_dst    = RD_RD;
        reg_write  = 1'b1;
        mem_to_reg = (funct == FN_SLT) ? M2R_SLT : M2R_ALUOUT;
        state_d    = S_FETCH;
      end
      S_EXEC_I: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_IMM;
        state_d   = overflow ? S_EXC : S_WB_I;
      end
      S_WB_I: begin
        reg_write = 1'b1;
        state_d   = S_FETCH;
      end
      S_MEM_ADDR: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_IMM;
        state_d   = (opcode == OP_LW) ? S_MEM_RD : S_MEM_WR;
      end
      S_MEM_RD: begin
        i_or_d  = 1'b1;
        mem_rd  = 1'b1;
        wait_en = 1'b1;
        if (wait_done) begin
          state_d = S_WB_LW;
        end
      end
      S_WB_LW: begin
        mem_to_reg = M2R_MDR;
        reg_write  = 1'b1;
        state_d    = S_FETCH;
      end
      S_MEM_WR: begin
        i_or_d  = 1'b1;
        mem_wr  = 1'b1;
        state_d = S_FETCH;
      end
      S_BRANCH: begin
        alu_src_a     = 1'b1;
        alu_op        = ALU_SUB;
        pc_source     = PCS_ALUOUT;
        pc_write_cond = 1'b1;
        state_d       = S_FETCH;
      end
      S_JUMP: begin
        pc_source = PCS_JUMP;
        pc_write  = 1'b1;
        state_d   = S_FETCH;
      end
      S_JAL: begin
        pc_source  = PCS_JUMP;
        pc_write   = 1'b1;
        reg_dst    = RD_RA;
        mem_to_reg = M2R_PC;
        reg_write  = 1'b1;
        state_d    = S_FETCH;
      end
      S_LUI: begin
        mem_to_reg = M2R_LUI;
        reg_write  = 1'b1;
        state_d    = S_FETCH;
      end
      S_EXC: begin
        epc_write = 1'b1;
        alu_src_b = SRCB_FOUR;
        alu_op    = ALU_SUB;
        pc_source = PCS_EXC;
        pc_write  = 1'b1;
        state_d   = S_FETCH;
      end
      default: begin
        state_d = S_FETCH;
      end
    endcase
  end

  // State register; reset abandons any instruction in flight
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_FETCH;
    end else begin
      state_q <= state_d;
    end
  end

  assign state_dbg = state_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl with MEM_WAIT=1 (two-cycle fetch
// and memory read).
module tb_multicycle_ctrl;

  localparam int ST_FETCH    = 0;
  localparam int ST_DECODE   = 1;
  localparam int ST_EXEC_R   = 2;
  localparam int ST_WB_R     = 3;
  localparam int ST_EXEC_I   = 4;
  localparam int ST_MEM_ADDR = 6;
  localparam int ST_MEM_RD   = 7;
  localparam int ST_WB_LW    = 8;
  localparam int ST_MEM_WR   = 9;
  localparam int ST_BRANCH   = 10;
  localparam int ST_JUMP     = 11;
  localparam int ST_JAL      = 12;
  localparam int ST_EXC      = 14;

  logic       clk;
  logic       reset_n;
  logic [5:0] opcode;
  logic [5:0] funct;
  logic       zero;
  logic       overflow;
  logic       pc_write;
  logic       pc_write_cond;
  logic       i_or_d;
  logic       mem_rd;
  logic       mem_wr;
  logic       ir_write;
  logic [1:0] reg_dst;
  logic [2:0] mem_to_reg;
  logic       reg_write;
  logic       alu_src_a;
  logic [1:0] alu_src_b;
  logic [2:0] alu_op;
  logic [1:0] pc_source;
  logic       epc_write;
  logic [4:0] state_dbg;

  int pass_count  = 0;
  int fail_count  = 0;
  int total_count = 0;

  multicycle_ctrl #(
    .MEM_WAIT (1)
  ) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .opcode        (opcode),
    .funct         (funct),
    .zero          (zero),
    .overflow      (overflow),
    .pc_write      (pc_write),
    .pc_write_cond (pc_write_cond),
    .i_or_d        (i_or_d),
    .mem_rd        (mem_rd),
    .mem_wr        (mem_wr),
    .ir_write      (ir_write),
    .reg_dst       (reg_dst),
    .mem_to_reg    (mem_to_reg),
    .reg_write     (reg_write),
    .alu_src_a     (alu_src_a),
    .alu_src_b     (alu_src_b),
    .alu_op        (alu_op),
    .pc_source     (pc_source),
    .epc_write     (epc_write),
    .state_dbg     (state_dbg)
  );

  // 10 ns clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one cycle and settle just after the edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Advance from FETCH cycle 1 to the first post-decode state (cycle 4)
  task automatic to_exec();
    step();
    step();
    step();
  endtask

  // One comparison of an observed output against its expected value
  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp_v);
    total_count++;
    assert (obs === exp_v) pass_count++;
    else begin
      fail_count++;
      $error("[TB] FAIL %s: got %0d, expected %0d", tag, obs, exp_v);
    end
  endtask

  // Directed sequence
  initial begin
    reset_n  = 1'b0;
    opcode   = 6'h00;
    funct    = 6'h20;
    zero     = 1'b0;
    overflow = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // Reset state
    check("rst_state", 8'(state_dbg), 8'(ST_FETCH));
    check("rst_mem_rd", 8'(mem_rd), 8'd1);
    check("rst_reg_write", 8'(reg_write), 8'd0);
    check("rst_pc_write", 8'(pc_write), 8'd0);
    check("rst_ir_write", 8'(ir_write), 8'd0);
    check("rst_mem_wr", 8'(mem_wr), 8'd0);
    check("rst_epc_write", 8'(epc_write), 8'd0);
    reset_n = 1'b1;

    // add, no overflow: 5 cycles
    opcode = 6'h00;
    funct  = 6'h20;
    check("add_c1_ir_write", 8'(ir_write), 8'd0);
    check("add_c1_alu_src_b", 8'(alu_src_b), 8'd1);
    step();
    check("add_c2_ir_write", 8'(ir_write), 8'd1);
    check("add_c2_pc_write", 8'(pc_write), 8'd1);
    check("add_c2_mem_rd", 8'(mem_rd), 8'd1);
    step();
    check("add_c3_state", 8'(state_dbg), 8'(ST_DECODE));
    check("add_c3_alu_src_b", 8'(alu_src_b), 8'd3);
    step();
    check("add_c4_state", 8'(state_dbg), 8'(ST_EXEC_R));
    check("add_c4_alu_src_a", 8'(alu_src_a), 8'd1);
    check("add_c4_alu_src_b", 8'(alu_src_b), 8'd0);
    check("add_c4_alu_op", 8'(alu_op), 8'd0);
    step();
    check("add_c5_state", 8'(state_dbg), 8'(ST_WB_R));
    check("add_c5_reg_write", 8'(reg_write), 8'd1);
    check("add_c5_reg_dst", 8'(reg_dst), 8'd1);
    check("add_c5_mem_to_reg", 8'(mem_to_reg), 8'd0);
    step();
    check("add_c6_state", 8'(state_dbg), 8'(ST_FETCH));

    // lw: 7 cycles, mem_rd held 2 cycles in each memory access
    opcode = 6'h23;
    check("lw_c1_mem_rd", 8'(mem_rd), 8'd1);
    step();
    check("lw_c2_mem_rd", 8'(mem_rd), 8'd1);
    step();
    check("lw_c3_mem_rd", 8'(mem_rd), 8'd0);
    step();
    check("lw_c4_state", 8'(state_dbg), 8'(ST_MEM_ADDR));
    check("lw_c4_alu_src_b", 8'(alu_src_b), 8'd2);
    step();
    check("lw_c5_state", 8'(state_dbg), 8'(ST_MEM_RD));
    check("lw_c5_mem_rd", 8'(mem_rd), 8'd1);
    check("lw_c5_i_or_d", 8'(i_or_d), 8'd1);
    step();
    check("lw_c6_state", 8'(state_dbg), 8'(ST_MEM_RD));
    check("lw_c6_mem_rd", 8'(mem_rd), 8'd1);
    step();
    check("lw_c7_state", 8'(state_dbg), 8'(ST_WB_LW));
    check("lw_c7_mem_to_reg", 8'(mem_to_reg), 8'd1);
    check("lw_c7_reg_write", 8'(reg_write), 8'd1);
    check("lw_c7_mem_rd", 8'(mem_rd), 8'd0);
    step();
    check("lw_c8_state", 8'(state_dbg), 8'(ST_FETCH));

    // sw: one-cycle write then back to FETCH
    opcode = 6'h2b;
    to_exec();
    step();
    check("sw_c5_state", 8'(state_dbg), 8'(ST_MEM_WR));
    check("sw_c5_mem_wr", 8'(mem_wr), 8'd1);
    check("sw_c5_i_or_d", 8'(i_or_d), 8'd1);
    step();
    check("sw_c6_state", 8'(state_dbg), 8'(ST_FETCH));
    check("sw_c6_mem_wr", 8'(mem_wr), 8'd0);

    // beq taken and not taken use the same strobes
    opcode = 6'h04;
    zero   = 1'b1;
    to_exec();
    check("beq_z1_state", 8'(state_dbg), 8'(ST_BRANCH));
    check("beq_z1_pc_write_cond", 8'(pc_write_cond), 8'd1);
    check("beq_z1_pc_source", 8'(pc_source), 8'd1);
    check("beq_z1_alu_op", 8'(alu_op), 8'd1);
    check("beq_z1_pc_write", 8'(pc_write), 8'd0);
    step();
    check("beq_z1_next", 8'(state_dbg), 8'(ST_FETCH));
    zero = 1'b0;
    to_exec();
    check("beq_z0_pc_write_cond", 8'(pc_write_cond), 8'd1);
    check("beq_z0_pc_source", 8'(pc_source), 8'd1);
    check("beq_z0_pc_write", 8'(pc_write), 8'd0);
    step();

    // jal: link and jump in one cycle
    opcode = 6'h03;
    to_exec();
    check("jal_state", 8'(state_dbg), 8'(ST_JAL));
    check("jal_reg_dst", 8'(reg_dst), 8'd2);
    check("jal_mem_to_reg", 8'(mem_to_reg), 8'd2);
    check("jal_pc_source", 8'(pc_source), 8'd2);
    check("jal_pc_write", 8'(pc_write), 8'd1);
    check("jal_reg_write", 8'(reg_write), 8'd1);
    step();

    // lui writes the shifted immediate
    opcode = 6'h0f;
    to_exec();
    check("lui_mem_to_reg", 8'(mem_to_reg), 8'd3);
    check("lui_reg_write", 8'(reg_write), 8'd1);
    step();
    check("lui_next", 8'(state_dbg), 8'(ST_FETCH));

    // slt selects the slt bit on write-back
    opcode = 6'h00;
    funct  = 6'h2a;
    to_exec();
    check("slt_alu_op", 8'(alu_op), 8'd4);
    step();
    check("slt_mem_to_reg", 8'(mem_to_reg), 8'd4);
    check("slt_reg_write", 8'(reg_write), 8'd1);
    step();

    // add with overflow traps instead of writing back
    funct = 6'h20;
    to_exec();
    overflow = 1'b1;
    step();
    check("addovf_state", 8'(state_dbg), 8'(ST_EXC));
    check("addovf_reg_write", 8'(reg_write), 8'd0);
    overflow = 1'b0;
    step();

    // addi with overflow traps
    opcode = 6'h08;
    to_exec();
    check("addi_state", 8'(state_dbg), 8'(ST_EXEC_I));
    check("addi_alu_src_b", 8'(alu_src_b), 8'd2);
    overflow = 1'b1;
    step();
    check("addiovf_state", 8'(state_dbg), 8'(ST_EXC));
    check("addiovf_epc_write", 8'(epc_write), 8'd1);
    check("addiovf_pc_source", 8'(pc_source), 8'd3);
    check("addiovf_pc_write", 8'(pc_write), 8'd1);
    check("addiovf_alu_op", 8'(alu_op), 8'd1);
    check("addiovf_reg_write", 8'(reg_write), 8'd0);
    overflow = 1'b0;
    step();
    check("addiovf_next", 8'(state_dbg), 8'(ST_FETCH));

    // illegal opcode traps straight from DECODE
    opcode = 6'h3f;
    to_exec();
    check("illop_state", 8'(state_dbg), 8'(ST_EXC));
    check("illop_epc_write", 8'(epc_write), 8'd1);
    check("illop_pc_source", 8'(pc_source), 8'd3);
    check("illop_reg_write", 8'(reg_write), 8'd0);
    step();

    // illegal R-type funct traps too
    opcode = 6'h00;
    funct  = 6'h00;
    to_exec();
    check("illfn_state", 8'(state_dbg), 8'(ST_EXC));
    step();

    // reset asserted mid-EXEC_R abandons the sub
    funct = 6'h22;
    to_exec();
    check("rstmid_pre_state", 8'(state_dbg), 8'(ST_EXEC_R));
    reset_n = 1'b0;
    #1;
    check("rstmid_async_state", 8'(state_dbg), 8'(ST_FETCH));
    check("rstmid_reg_write", 8'(reg_write), 8'd0);
    opcode = 6'h02;
    step();
    check("rstmid_hold_state", 8'(state_dbg), 8'(ST_FETCH));
    check("rstmid_hold_reg_write", 8'(reg_write), 8'd0);
    reset_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      check("rstmid_after_reg_write", 8'(reg_write), 8'd0);
      step();
    end
    check("j_state", 8'(state_dbg), 8'(ST_JUMP));
    check("j_pc_write", 8'(pc_write), 8'd1);
    check("j_pc_source", 8'(pc_source), 8'd2);
    check("j_reg_write", 8'(reg_write), 8'd0);
    step();
    check("j_next", 8'(state_dbg), 8'(ST_FETCH));

    $display("[TB] %0d/%0d checks passed", pass_count, total_count);
    $finish;
  end

endmodule
